// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC fetch path: opcodes, instruction field
// positions, the halt word and the fetch FSM state encoding.
package sisc_pkg;

    typedef enum logic [3:0] {
        OP_NOOP = 4'h0,
        OP_LD   = 4'h1,
        OP_STR  = 4'h2,
        OP_BRA  = 4'h3,
        OP_XOR  = 4'h4,
        OP_ADD  = 4'h5,
        OP_ROT  = 4'h6,
        OP_SHF  = 4'h7,
        OP_CMP  = 4'h8,
        OP_HLT  = 4'hF
    } opcode_e;

    localparam int OPC_MSB = 31;
    localparam int MM_MSB  = 27;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 16;

    localparam logic [31:0] HLT_WORD = 32'hF000_0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/sisc_next_pc.sv
// Next-PC selection: sequential increment, absolute target, or PC-relative
// target with a sign-extended 16-bit immediate. All results wrap modulo 2^PC_W.
module sisc_next_pc
    import sisc_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [IMM_W-1:0] imm,
    input  logic             pc_sel,
    input  logic             br_sel,
    output logic [PC_W-1:0]  next_pc
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    // Select the candidate PC; the adders simply drop the carry to wrap.
    always_comb begin
        next_pc = pc;
        if (!pc_sel) begin
            next_pc = pc + PC_ONE;
        end else if (br_sel) begin
            next_pc = PC_W'(imm);
        end else begin
            next_pc = pc + PC_W'($signed(imm));
        end
    end

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC fetch unit: program counter, instruction register and a two-state
// fetch FSM talking to instruction memory over a req/ack handshake.
module sisc_fetch_unit
    import sisc_pkg::*;
#(
    parameter int PC_W     = 16,
    parameter int INSTR_W  = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic               pc_rst,
    input  logic               pc_write,
    input  logic               pc_sel,
    input  logic               br_sel,
    input  logic               ir_load,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    pc_out,
    output logic [INSTR_W-1:0] ir,
    output logic [3:0]         opcode,
    output logic [3:0]         mm,
    output logic               stall,
    output logic               fetch_err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    fetch_state_e        state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [PC_W-1:0]     pc_r, pc_s, next_pc_s, addr_r, addr_s;
    logic [INSTR_W-1:0]  ir_r, ir_s;
    logic                err_r, err_s, req_r, stall_r;

    sisc_next_pc #(.PC_W(PC_W)) u_next_pc (
        .pc      (pc_r),
        .imm     (ir_r[IMM_LSB +: IMM_W]),
        .pc_sel  (pc_sel),
        .br_sel  (br_sel),
        .next_pc (next_pc_s)
    );

    // Fetch FSM, PC update and IR capture; pc_rst overrides everything.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        pc_s    = pc_r;
        addr_s  = addr_r;
        ir_s    = ir_r;
        err_s   = err_r;
        if (pc_rst) begin
            state_s = ST_IDLE;
            cnt_s   = '0;
            pc_s    = '0;
            ir_s    = '0;
            err_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ir_load) begin
                        state_s = ST_WAIT;
                        cnt_s   = '0;
                        addr_s  = pc_r;
                    end else begin
                        state_s = ST_IDLE;
                    end
                    // PC moves only while no fetch is outstanding.
                    if (pc_write) begin
                        pc_s = next_pc_s;
                    end else begin
                        pc_s = pc_r;
                    end
                end
                ST_WAIT: begin
                    if (imem_ack) begin
                        ir_s    = imem_rdata;
                        state_s = ST_IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        ir_s    = INSTR_W'(HLT_WORD);
                        err_s   = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            pc_r    <= '0;
            addr_r  <= '0;
            ir_r    <= '0;
            err_r   <= 1'b0;
            req_r   <= 1'b0;
            stall_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            pc_r    <= pc_s;
            addr_r  <= addr_s;
            ir_r    <= ir_s;
            err_r   <= err_s;
            req_r   <= (state_s == ST_WAIT);
            stall_r <= (state_s == ST_WAIT);
        end
    end

    assign imem_req  = req_r;
    assign stall     = stall_r;
    assign imem_addr = addr_r;
    assign pc_out    = pc_r;
    assign ir        = ir_r;
    assign fetch_err = err_r;
    assign opcode    = ir_r[OPC_MSB -: 4];
    assign mm        = ir_r[MM_MSB -: 4];

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Self-checking bench for sisc_fetch_unit: directed scenarios plus randomized
// traffic, compared each cycle against a transaction-level model.
module tb_sisc_fetch_unit;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic        pc_rst = 1'b0, pc_write = 1'b0, pc_sel = 1'b0, br_sel = 1'b0;
    logic        ir_load = 1'b0, imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req, stall, fetch_err;
    logic [15:0] imem_addr, pc_out;
    logic [31:0] ir;
    logic [3:0]  opcode, mm;

    int passed = 0;
    int total  = 0;

    // Reference model state
    int          m_pc = 0;
    logic [31:0] m_ir = 32'h0;
    bit          m_err = 1'b0;
    bit          m_busy = 1'b0;
    int          m_waited = 0;
    int          m_addr = 0;

    sisc_fetch_unit #(.PC_W(16), .INSTR_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_f(rst_f), .pc_rst(pc_rst), .pc_write(pc_write),
        .pc_sel(pc_sel), .br_sel(br_sel), .ir_load(ir_load),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .pc_out(pc_out), .ir(ir), .opcode(opcode),
        .mm(mm), .stall(stall), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int branch_target(input int pc, input logic [31:0] w,
                                         input bit sel, input bit br);
        int imm;
        if (!sel) return (pc + 1) % 65536;
        if (br) return int'(w[15:0]);
        imm = int'(w[15:0]);
        if (imm >= 32768) imm -= 65536;
        return (pc + imm + 65536) % 65536;
    endfunction

    // What one clock edge does, in terms of the fetch transaction.
    task automatic model_edge();
        if (pc_rst) begin
            m_pc = 0; m_ir = 32'h0; m_err = 1'b0; m_busy = 1'b0;
        end else if (m_busy) begin
            if (imem_ack) begin
                m_ir = imem_rdata; m_busy = 1'b0;
            end else begin
                m_waited++;
                if (m_waited == MAX_WAIT) begin
                    m_ir = 32'hF000_0000; m_err = 1'b1; m_busy = 1'b0;
                end
            end
        end else begin
            if (ir_load) begin
                m_busy = 1'b1; m_waited = 0; m_addr = m_pc;
            end
            if (pc_write) m_pc = branch_target(m_pc, m_ir, pc_sel, br_sel);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_ir = 32'h0; m_err = 1'b0; m_busy = 1'b0; m_waited = 0; m_addr = 0;
    endtask

    task automatic compare_all();
        chk("pc_out", 32'(pc_out), 32'(m_pc));
        chk("ir", ir, m_ir);
        chk("opcode", 32'(opcode), 32'(m_ir[31:28]));
        chk("mm", 32'(mm), 32'(m_ir[27:24]));
        chk("stall", 32'(stall), 32'(m_busy));
        chk("imem_req", 32'(imem_req), 32'(m_busy));
        chk("fetch_err", 32'(fetch_err), 32'(m_err));
        if (m_busy) chk("imem_addr", 32'(imem_addr), 32'(m_addr));
    endtask

    // Called at a negedge: drive inputs, advance model, check at next negedge.
    task automatic cyc(input bit rs, input bit pw, input bit ps, input bit bs,
                       input bit il, input bit ak, input logic [31:0] rd);
        pc_rst = rs; pc_write = pw; pc_sel = ps; br_sel = bs;
        ir_load = il; imem_ack = ak; imem_rdata = rd;
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] w);
        cyc(0, 0, 0, 0, 1, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 1, w);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_f = 1'b1;
        chk("rst_pc", 32'(pc_out), 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_err", 32'(fetch_err), 32'h0);
        compare_all();

        // First fetch, ack one cycle after request
        cyc(0, 0, 0, 0, 1, 0, 32'h0);
        chk("f1_req", 32'(imem_req), 32'h1);
        chk("f1_addr", 32'(imem_addr), 32'h0);
        cyc(0, 0, 0, 0, 0, 1, 32'h8123_0004);
        chk("f1_ir", ir, 32'h8123_0004);
        chk("f1_opc", 32'(opcode), 32'h8);
        chk("f1_mm", 32'(mm), 32'h1);
        chk("f1_stall", 32'(stall), 32'h0);

        // Sequential and wrap
        fetch(32'h0000_0010);
        cyc(0, 1, 1, 1, 0, 0, 32'h0);
        chk("abs_10", 32'(pc_out), 32'h10);
        cyc(0, 1, 0, 0, 0, 0, 32'h0);
        chk("seq_11", 32'(pc_out), 32'h11);
        fetch(32'h0000_FFFF);
        cyc(0, 1, 1, 1, 0, 0, 32'h0);
        cyc(0, 1, 0, 0, 0, 0, 32'h0);
        chk("seq_wrap", 32'(pc_out), 32'h0);

        // Branches
        fetch(32'h0000_0040);
        cyc(0, 1, 1, 1, 0, 0, 32'h0);
        chk("abs_40", 32'(pc_out), 32'h40);
        fetch(32'h0000_0010);
        cyc(0, 1, 1, 1, 0, 0, 32'h0);
        fetch(32'h0000_FFF8);
        cyc(0, 1, 1, 0, 0, 0, 32'h0);
        chk("rel_neg", 32'(pc_out), 32'h8);

        // Timeout with pc_write and ir_load held during the wait
        cyc(0, 0, 0, 0, 1, 0, 32'h0);
        for (int i = 1; i < MAX_WAIT; i++) cyc(0, 1, 0, 0, 1, 0, 32'h0);
        chk("to_still_stall", 32'(stall), 32'h1);
        chk("to_pc_hold", 32'(pc_out), 32'h8);
        cyc(0, 0, 0, 0, 0, 0, 32'h0);
        chk("to_ir", ir, 32'hF000_0000);
        chk("to_err", 32'(fetch_err), 32'h1);
        chk("to_stall", 32'(stall), 32'h0);
        repeat (3) idle();
        chk("err_sticky", 32'(fetch_err), 32'h1);
        cyc(1, 0, 0, 0, 0, 0, 32'h0);
        chk("prst_err", 32'(fetch_err), 32'h0);

        // Only one ack consumed while ir_load is held
        cyc(0, 0, 0, 0, 1, 0, 32'h0);
        cyc(0, 0, 0, 0, 1, 0, 32'h0);
        cyc(0, 0, 0, 0, 1, 1, 32'h1234_5678);
        cyc(0, 0, 0, 0, 0, 1, 32'h9999_9999);
        chk("one_ack", ir, 32'h1234_5678);

        // pc_rst abandons an outstanding fetch; late ack ignored
        cyc(0, 1, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 1, 0, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 1, 32'hABCD_0001);
        chk("late_ir", ir, 32'h0);
        chk("late_pc", 32'(pc_out), 32'h0);
        chk("late_stall", 32'(stall), 32'h0);

        // rst_f mid-fetch clears immediately
        cyc(0, 1, 0, 0, 0, 0, 32'h0);
        fetch(32'h5555_AAAA);
        cyc(0, 0, 0, 0, 1, 0, 32'h0);
        #2 rst_f = 1'b0;
        #1;
        chk("arst_pc", 32'(pc_out), 32'h0);
        chk("arst_ir", ir, 32'h0);
        chk("arst_req", 32'(imem_req), 32'h0);
        chk("arst_stall", 32'(stall), 32'h0);
        chk("arst_addr", 32'(imem_addr), 32'h0);
        model_reset();
        @(negedge clk);
        rst_f = 1'b1;
        compare_all();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 63) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 9) < 2), $urandom());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
